// File: rtl/demux_dispatch_ctrl_if.sv
// Handshake bundle between the dispatch controller, its single producer and its two consumers.
// master = controller side, slave = producer/consumer side.
interface demux_dispatch_ctrl_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_dest;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] y1_data;
  logic          y1_valid;
  logic          y1_ready;
  logic [DW-1:0] y2_data;
  logic          y2_valid;
  logic          y2_ready;
  logic          sel;
  logic          busy;

  modport master (
    input  in_data, in_dest, in_valid, y1_ready, y2_ready,
    output in_ready, y1_data, y1_valid, y2_data, y2_valid, sel, busy
  );

  modport slave (
    output in_data, in_dest, in_valid, y1_ready, y2_ready,
    input  in_ready, y1_data, y1_valid, y2_data, y2_valid, sel, busy
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// One-word buffered 1:2 dispatch controller with round-robin or directed steering.
// Define DEMUX_DISPATCH_CNT_EN to add saturating per-channel delivery counters cnt1/cnt2.
//
// state | meaning
// IDLE  | buffer empty, accepting a word unless flushing
// SEND  | buffer holds a word, presented on the channel selected by target_q
module demux_dispatch_ctrl #(
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic                   flush,
  demux_dispatch_ctrl_if.master  bus
`ifdef DEMUX_DISPATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]       cnt1,
  output logic [CNT_W-1:0]       cnt2
`endif
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q;
  logic          target_q;
  logic          rr_ptr_q;
  logic          sel_ready;
  logic          ready_c;
  logic          done;
  logic          capture;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    ready_c      = 1'b0;
    done         = 1'b0;
    sel_ready    = target_q ? bus.y2_ready : bus.y1_ready;
    bus.y1_valid = 1'b0;
    bus.y2_valid = 1'b0;
    bus.sel      = 1'b0;
    bus.busy     = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = ~flush;
        if (bus.in_valid && ready_c) state_d = SEND;
      end
      SEND: begin
        bus.busy     = 1'b1;
        bus.sel      = target_q;
        bus.y1_valid = ~target_q;
        bus.y2_valid = target_q;
        done         = sel_ready;
        ready_c      = sel_ready & ~flush;
        if (done && !(bus.in_valid && ready_c)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // in_ready must read low for the whole reset interval, not just after the next edge
  assign bus.in_ready = ready_c & rst_n;
  assign capture      = bus.in_valid & bus.in_ready;
  assign bus.y1_data  = data_q;
  assign bus.y2_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      target_q <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else if (capture) begin
      data_q   <= bus.in_data;
      target_q <= mode ? bus.in_dest : rr_ptr_q;
      if (!mode) rr_ptr_q <= ~rr_ptr_q;
    end
  end

`ifdef DEMUX_DISPATCH_CNT_EN
  // A transfer completing in a flush cycle is still a delivery
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (done) begin
      if (!target_q && cnt1 != '1) cnt1 <= cnt1 + CNT_W'(1);
      if (target_q && cnt2 != '1)  cnt2 <= cnt2 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
- Controller that sequences a 1:2 demultiplexer datapath.
- Accepts a valid/ready input word stream, buffers one word and selects an output channel (Y1 or Y2) per word.
- Drives the demux select and per-channel valid/ready handshakes.
- Sits between a single producer and two consumers; replaces a free-running select with scheduled, back-pressure-aware steering.

Parameters:
DW, 8, data word width
CNT_W, 8, width of per-channel delivery counters (optional feature only)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = round-robin steering, 1 = destination-directed steering
flush  input  1  synchronous drop of held word
in_data  input  DW  input word
in_dest  input  1  destination for mode 1: 0 -> Y1, 1 -> Y2
in_valid  input  1  input word valid
in_ready  output  1  controller can accept input this cycle
y1_data  output  DW  channel-1 data
y1_valid  output  1  channel-1 word valid
y1_ready  input  1  channel-1 consumer ready
y2_data  output  DW  channel-2 data
y2_valid  output  1  channel-2 word valid
y2_ready  input  1  channel-2 consumer ready
sel  output  1  demux select of held word: 0 = Y1, 1 = Y2
busy  output  1  buffer holds an undelivered word

Behaviour:
- Single clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, data buffer 0, rr_ptr 0, sel 0, busy 0, y1/y2_valid 0, y1/y2_data 0.
- in_ready is forced 0 while rst_n is low.

FSM states and transitions:
- IDLE:
  - in_ready = 1 unless flush.
  - in_valid & in_ready -> capture in_data, compute target -> SEND.
- SEND:
  - busy = 1; sel = target.
  - Exactly one of y1_valid/y2_valid is 1 (y1_valid when sel=0).
  - Held data drives both y1_data and y2_data; the non-selected channel's valid is 0.
- Transfer:
  - Completes when the selected valid and its ready are both 1.
  - The other channel's ready is ignored.
- in_ready in SEND = ready of the selected channel & ~flush.
  - On completion with in_valid = 1: capture the new word in the same cycle and stay in SEND. Throughput is one word per cycle.
  - On completion with in_valid = 0 -> IDLE.
- Latency: a captured word is presented on its channel the cycle after capture. There is no combinational path from in_data to y*_data.

Target selection, computed at capture:
- mode=1: target = in_dest.
- mode=0: target = rr_ptr, and rr_ptr toggles on every capture made in mode 0.
- mode is sampled at capture only. A mode change while in SEND does not alter the held word's target.
- rr_ptr holds its value across mode-1 captures.

Boundary conditions:
- valid is held high with data stable until the handshake completes. The controller never withdraws valid or changes sel while in SEND.
- flush=1: next state IDLE, held word discarded, y*_valid 0 next cycle, rr_ptr unchanged.
  - in_ready = 0 during flush, so nothing is captured.
  - A transfer completing in the flush cycle still counts as delivered.
- Both consumers not ready: held indefinitely, in_ready = 0.
- Reset mid-SEND: word lost, all outputs return to reset values immediately.

Optional Feature:
Macro DEMUX_DISPATCH_CNT_EN.
- Defined:
  - Adds outputs cnt1 and cnt2 (CNT_W each).
  - Each increments by 1 per completed transfer on Y1 / Y2 respectively.
  - Saturating at 2^CNT_W-1 (no wrap).
  - Cleared only by rst_n; not cleared by flush.
- Undefined: ports and counter logic absent; all other behaviour identical.

Test Plan:
- Round-robin: mode=0, consumers always ready, stream 0x11,0x22,0x33,0x44 back-to-back -> Y1 gets 0x11,0x33; Y2 gets 0x22,0x44; one word per cycle, sel alternates 0,1,0,1.
- Directed steering: mode=1, in_dest 1,1,0 with data 0xA0,0xA1,0xA2 -> Y2 gets 0xA0,0xA1; Y1 gets 0xA2; y1_valid never high with y2_valid.
- Back-pressure: mode=1, dest 0, y1_ready=0 for 5 cycles while y2_ready=1 -> y1_valid=1 with 0x5A stable, in_ready=0, busy=1 for 5 cycles; delivered in the cycle y1_ready rises.
- Flush: hold word 0x77 to Y2 with y2_ready=0, pulse flush -> next cycle y2_valid=0, busy=0, in_ready=1; 0x77 never delivered.
- Async reset mid-SEND: assert rst_n=0 between edges while y1_valid=1 -> y1_valid, busy, sel, in_ready go 0 immediately; after release the first mode-0 word goes to Y1.
- Counters (macro defined, CNT_W=2): send 5 words to Y1 -> cnt1 = 3 (saturated), cnt2 = 0; flush leaves both unchanged.
